// File: rtl/fib_chk_pkg.sv
// Shared constants and state encodings for the Fibonacci trace checker.
package fib_chk_pkg;

  localparam int FIB_W_DEF   = 11;
  localparam int ERR_CNT_W   = 8;
  localparam int MATCH_CNT_W = 16;
  localparam int COV_CNT_W   = 16;

  typedef logic [1:0] fib_state_t;

  localparam fib_state_t ST_IDLE  = 2'd0;
  localparam fib_state_t ST_SEED  = 2'd1;
  localparam fib_state_t ST_TRACK = 2'd2;
  localparam fib_state_t ST_FAIL  = 2'd3;

endpackage

// File: rtl/fib_step.sv
// One step of the observed generator: advance (x, y) when selector is set, else hold.
module fib_step
  import fib_chk_pkg::*;
#(
  parameter int W = FIB_W_DEF
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         selector,
  output logic [W-1:0] pred_x,
  output logic [W-1:0] pred_y
);

  // Sum is deliberately W bits wide: the carry out is dropped (mod 2^W).
  logic [W-1:0] sum;

  assign sum    = x + y;
  assign pred_x = selector ? y   : x;
  assign pred_y = selector ? sum : y;

endmodule

// File: rtl/fib_trace_checker.sv
// Checks an observed (x, y) trace against the Fibonacci step model.
// Optional FIB_CHK_COVER_EN adds hold_cnt/step_cnt coverage counters.
//
// state | meaning
// IDLE  | no reference yet; next accepted sample becomes the seed
// SEED  | seed stored; next accepted sample is the first check
// TRACK | checking every accepted sample against the predicted step
// FAIL  | mismatch latched (STOP_ON_FAIL=1); samples ignored until clr/rst
module fib_trace_checker
  import fib_chk_pkg::*;
#(
  parameter int W            = FIB_W_DEF,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   selector,
  input  logic [W-1:0]           x,
  input  logic [W-1:0]           y,
  output logic [1:0]             state,
`ifdef FIB_CHK_COVER_EN
  output logic [COV_CNT_W-1:0]   hold_cnt,
  output logic [COV_CNT_W-1:0]   step_cnt,
`endif
  output logic                   err,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  output logic [MATCH_CNT_W-1:0] match_cnt
);

  fib_state_t   state_q;
  logic [W-1:0] seed_x;
  logic [W-1:0] seed_y;
  logic         seed_sel;
  logic [W-1:0] pred_x;
  logic [W-1:0] pred_y;
  logic         accept;
  logic         checking;
  logic         hit;

  fib_step #(.W(W)) u_step (
    .x        (seed_x),
    .y        (seed_y),
    .selector (seed_sel),
    .pred_x   (pred_x),
    .pred_y   (pred_y)
  );

  assign accept   = en && (state_q != ST_FAIL);
  assign checking = accept && ((state_q == ST_SEED) || (state_q == ST_TRACK));
  assign hit      = (x == pred_x) && (y == pred_y);
  assign state    = state_q;

  // On both match and resync the current sample becomes the new reference.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      seed_x    <= '0;
      seed_y    <= '0;
      seed_sel  <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      match_cnt <= '0;
    end else if (clr) begin
      state_q   <= ST_IDLE;
      seed_x    <= '0;
      seed_y    <= '0;
      seed_sel  <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      match_cnt <= '0;
    end else if (accept) begin
      seed_x   <= x;
      seed_y   <= y;
      seed_sel <= selector;
      if (state_q == ST_IDLE) begin
        state_q <= ST_SEED;
      end else if (hit) begin
        state_q <= ST_TRACK;
        if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
      end else begin
        state_q <= STOP_ON_FAIL ? ST_FAIL : ST_TRACK;
        err     <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

`ifdef FIB_CHK_COVER_EN
  // Classified by the step selector that produced the prediction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
      step_cnt <= '0;
    end else if (clr) begin
      hold_cnt <= '0;
      step_cnt <= '0;
    end else if (checking) begin
      if (seed_sel) begin
        if (step_cnt != '1) step_cnt <= step_cnt + 1'b1;
      end else begin
        if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fib_trace_checker.sv
// Directed bench for fib_trace_checker: one instance latching on failure, one resynchronising.
module tb_fib_trace_checker;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic         clr = 1'b0;
  logic         sel = 1'b0;
  logic [W-1:0] x   = '0;
  logic [W-1:0] y   = '0;

  logic [1:0]   a_state, b_state;
  logic         a_err, b_err;
  logic [7:0]   a_err_cnt, b_err_cnt;
  logic [15:0]  a_match, b_match;
`ifdef FIB_CHK_COVER_EN
  logic [15:0]  a_hold, a_step, b_hold, b_step;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fib_trace_checker #(.W(W), .STOP_ON_FAIL(1'b1)) u_stop (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .selector(sel), .x(x), .y(y),
    .state(a_state),
`ifdef FIB_CHK_COVER_EN
    .hold_cnt(a_hold), .step_cnt(a_step),
`endif
    .err(a_err), .err_cnt(a_err_cnt), .match_cnt(a_match)
  );

  fib_trace_checker #(.W(W), .STOP_ON_FAIL(1'b0)) u_sync (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .selector(sel), .x(x), .y(y),
    .state(b_state),
`ifdef FIB_CHK_COVER_EN
    .hold_cnt(b_hold), .step_cnt(b_step),
`endif
    .err(b_err), .err_cnt(b_err_cnt), .match_cnt(b_match)
  );

  // Called at a negedge; presents one sample across the next posedge.
  task automatic smp(input logic [W-1:0] xi, input logic [W-1:0] yi, input logic si);
    en = 1'b1; x = xi; y = yi; sel = si;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if (a_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", a_state); end
    n_chk++; if (a_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0d expected 0", a_err); end
    n_chk++; if (a_err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_err_cnt: got %0d expected 0", a_err_cnt); end
    n_chk++; if (b_match !== 16'd0) begin n_err++; $display("FAIL reset_match_cnt: got %0d expected 0", b_match); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fib_trace();
    smp(11'd1, 11'd1, 1'b1);
    n_chk++; if (a_state !== 2'd1) begin n_err++; $display("FAIL fib_seed_state: got %0d expected 1", a_state); end
    n_chk++; if (a_match !== 16'd0) begin n_err++; $display("FAIL fib_seed_match: got %0d expected 0", a_match); end
    smp(11'd1, 11'd2, 1'b1);
    smp(11'd2, 11'd3, 1'b1);
    repeat (3) @(negedge clk);
    n_chk++; if (a_match !== 16'd2) begin n_err++; $display("FAIL fib_gap_match: got %0d expected 2", a_match); end
    n_chk++; if (a_state !== 2'd2) begin n_err++; $display("FAIL fib_gap_state: got %0d expected 2", a_state); end
    smp(11'd3, 11'd5, 1'b1);
    smp(11'd5, 11'd8, 1'b1);
    n_chk++; if (a_match !== 16'd4) begin n_err++; $display("FAIL fib_match: got %0d expected 4", a_match); end
    n_chk++; if (a_err !== 1'b0) begin n_err++; $display("FAIL fib_err: got %0d expected 0", a_err); end
    n_chk++; if (a_state !== 2'd2) begin n_err++; $display("FAIL fib_state: got %0d expected 2", a_state); end
    do_clr();
  endtask

  task automatic test_wrap();
    smp(11'd1000, 11'd1500, 1'b1);
    smp(11'd1500, 11'd452, 1'b1);
    n_chk++; if (a_match !== 16'd1) begin n_err++; $display("FAIL wrap_match: got %0d expected 1", a_match); end
    n_chk++; if (a_err !== 1'b0) begin n_err++; $display("FAIL wrap_err: got %0d expected 0", a_err); end
    smp(11'(2500), 11'(2500), 1'b1);
    n_chk++; if (a_err !== 1'b1) begin n_err++; $display("FAIL wrap_bad_err: got %0d expected 1", a_err); end
    n_chk++; if (a_state !== 2'd3) begin n_err++; $display("FAIL wrap_bad_state: got %0d expected 3", a_state); end
    do_clr();
  endtask

  task automatic test_hold();
    smp(11'd3, 11'd5, 1'b0);
    smp(11'd3, 11'd5, 1'b0);
    smp(11'd3, 11'd5, 1'b1);
    n_chk++; if (a_match !== 16'd2) begin n_err++; $display("FAIL hold_match: got %0d expected 2", a_match); end
    smp(11'd5, 11'd8, 1'b1);
    n_chk++; if (a_match !== 16'd3) begin n_err++; $display("FAIL hold_step_match: got %0d expected 3", a_match); end
    n_chk++; if (a_err !== 1'b0) begin n_err++; $display("FAIL hold_err: got %0d expected 0", a_err); end
`ifdef FIB_CHK_COVER_EN
    n_chk++; if (a_hold !== 16'd2) begin n_err++; $display("FAIL hold_cnt: got %0d expected 2", a_hold); end
    n_chk++; if (a_step !== 16'd1) begin n_err++; $display("FAIL step_cnt: got %0d expected 1", a_step); end
`endif
    do_clr();
  endtask

  task automatic test_fail_resync();
    smp(11'd1, 11'd1, 1'b1);
    smp(11'd1, 11'd3, 1'b1);
    n_chk++; if (a_state !== 2'd3) begin n_err++; $display("FAIL stop_state: got %0d expected 3", a_state); end
    n_chk++; if (a_err_cnt !== 8'd1) begin n_err++; $display("FAIL stop_err_cnt: got %0d expected 1", a_err_cnt); end
    n_chk++; if (b_state !== 2'd2) begin n_err++; $display("FAIL sync_state_after_miss: got %0d expected 2", b_state); end
    n_chk++; if (b_err !== 1'b1) begin n_err++; $display("FAIL sync_err: got %0d expected 1", b_err); end
    smp(11'd3, 11'd4, 1'b1);
    smp(11'd9, 11'd9, 1'b1);
    n_chk++; if (a_err_cnt !== 8'd1) begin n_err++; $display("FAIL stop_hold_err_cnt: got %0d expected 1", a_err_cnt); end
    n_chk++; if (a_match !== 16'd0) begin n_err++; $display("FAIL stop_hold_match: got %0d expected 0", a_match); end
    n_chk++; if (a_state !== 2'd3) begin n_err++; $display("FAIL stop_hold_state: got %0d expected 3", a_state); end
    n_chk++; if (b_match !== 16'd1) begin n_err++; $display("FAIL sync_match: got %0d expected 1", b_match); end
    n_chk++; if (b_err_cnt !== 8'd2) begin n_err++; $display("FAIL sync_err_cnt: got %0d expected 2", b_err_cnt); end
  endtask

  task automatic test_clr_priority();
    clr = 1'b1; en = 1'b1; x = 11'd7; y = 11'd11; sel = 1'b1;
    @(negedge clk);
    clr = 1'b0; en = 1'b0;
    n_chk++; if (a_state !== 2'd0) begin n_err++; $display("FAIL clr_state: got %0d expected 0", a_state); end
    n_chk++; if (b_state !== 2'd0) begin n_err++; $display("FAIL clr_sync_state: got %0d expected 0", b_state); end
    n_chk++; if (b_err_cnt !== 8'd0) begin n_err++; $display("FAIL clr_err_cnt: got %0d expected 0", b_err_cnt); end
    n_chk++; if (b_match !== 16'd0) begin n_err++; $display("FAIL clr_match: got %0d expected 0", b_match); end
    n_chk++; if (a_err !== 1'b0) begin n_err++; $display("FAIL clr_err: got %0d expected 0", a_err); end
    smp(11'd2, 11'd2, 1'b0);
    n_chk++; if (a_state !== 2'd1) begin n_err++; $display("FAIL clr_reseed_state: got %0d expected 1", a_state); end
    do_clr();
  endtask

  task automatic test_async_reset();
    smp(11'd1, 11'd1, 1'b1);
    smp(11'd1, 11'd2, 1'b1);
    #2 rst = 1'b0;
    #1;
    n_chk++; if (a_state !== 2'd0) begin n_err++; $display("FAIL arst_state: got %0d expected 0", a_state); end
    n_chk++; if (a_match !== 16'd0) begin n_err++; $display("FAIL arst_match: got %0d expected 0", a_match); end
    @(negedge clk);
    rst = 1'b1;
    smp(11'd5, 11'd5, 1'b0);
    n_chk++; if (a_state !== 2'd1) begin n_err++; $display("FAIL arst_seed_state: got %0d expected 1", a_state); end
    n_chk++; if (a_match !== 16'd0) begin n_err++; $display("FAIL arst_seed_match: got %0d expected 0", a_match); end
    smp(11'd5, 11'd5, 1'b0);
    n_chk++; if (a_match !== 16'd1) begin n_err++; $display("FAIL arst_first_check: got %0d expected 1", a_match); end
    do_clr();
  endtask

  task automatic test_err_sat();
    smp(11'd0, 11'd0, 1'b0);
    for (int i = 1; i <= 254; i++) smp(11'(i), 11'(i), 1'b0);
    n_chk++; if (b_err_cnt !== 8'd254) begin n_err++; $display("FAIL err_cnt_254: got %0d expected 254", b_err_cnt); end
    for (int i = 255; i <= 260; i++) smp(11'(i), 11'(i), 1'b0);
    n_chk++; if (b_err_cnt !== 8'd255) begin n_err++; $display("FAIL err_cnt_sat: got %0d expected 255", b_err_cnt); end
    n_chk++; if (b_state !== 2'd2) begin n_err++; $display("FAIL err_sat_state: got %0d expected 2", b_state); end
    n_chk++; if (b_match !== 16'd0) begin n_err++; $display("FAIL err_sat_match: got %0d expected 0", b_match); end
    n_chk++; if (a_err_cnt !== 8'd1) begin n_err++; $display("FAIL stop_err_sat: got %0d expected 1", a_err_cnt); end
  endtask

  initial begin
    test_reset();
    test_fib_trace();
    test_wrap();
    test_hold();
    test_fail_resync();
    test_clr_priority();
    test_async_reset();
    test_err_sat();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
